// File: rtl/wrf_payload_fifo.sv
// wrf_payload_fifo
//   Buffers 16-bit payload words from pulse processing and hands them to the
//   WR fabric frame builder in whole frames of FRAME_WORDS words.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   IDLE     | no frame in progress; frame_ready when enough words stored
//   PREFETCH | one cycle loading the head word into pop_data
//   STREAM   | pop_valid high; words handed out until the frame is done
//
// Ports
//   wr_sys_clk   system clock, rising edge
//   wr_sys_rst   synchronous active-high reset
//   s_data       payload word in
//   s_valid      s_data valid
//   s_ready      FIFO can take a word this cycle
//   frame_ready  a full frame is buffered and no frame is in progress
//   frame_start  frame builder claims one frame (single-cycle pulse)
//   pop_valid    pop_data holds the current frame's head word
//   pop_data     head word, registered
//   pop          frame builder consumes pop_data
//   frame_done   pulse in the cycle after the frame's last word is popped
//   level        number of words stored
//   ovf_cnt      dropped input words
//
// Build option
//   WRF_PAYLOAD_OVF_CNT_EN  when defined, ovf_cnt is a saturating drop
//                           counter; otherwise it is tied to 0.
module wrf_payload_fifo #(
  parameter int DEPTH_LOG2  = 9,
  parameter int FRAME_WORDS = 106
) (
  input  logic                  wr_sys_clk,
  input  logic                  wr_sys_rst,
  input  logic [15:0]           s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  frame_ready,
  input  logic                  frame_start,
  output logic                  pop_valid,
  output logic [15:0]           pop_data,
  input  logic                  pop,
  output logic                  frame_done,
  output logic [DEPTH_LOG2:0]   level,
  output logic [15:0]           ovf_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = $clog2(FRAME_WORDS + 1);
  localparam logic [DEPTH_LOG2:0] FRAME_LEVEL = (DEPTH_LOG2 + 1)'(FRAME_WORDS);
  localparam logic [DEPTH_LOG2:0] LEVEL_ONE   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {IDLE, PREFETCH, STREAM} state_t;

  state_t                state, state_nxt;
  logic [15:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr, rd_ptr_inc;
  logic [CNT_W-1:0]      words_left;
  logic                  wr_en, pop_acc, last_pop, load_head;

  // level is one bit wider than the pointers, so full is simply its MSB.
  assign s_ready    = ~wr_sys_rst & ~level[DEPTH_LOG2];
  assign wr_en      = s_valid & s_ready;
  assign rd_ptr_inc = rd_ptr + PTR_ONE;

  always_ff @(posedge wr_sys_clk) begin
    if (wr_sys_rst) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    frame_ready = 1'b0;
    pop_valid   = 1'b0;
    load_head   = 1'b0;
    pop_acc     = 1'b0;
    last_pop    = 1'b0;
    case (state)
      IDLE: begin
        frame_ready = ~wr_sys_rst & (level >= FRAME_LEVEL);
        if (frame_start && frame_ready) state_nxt = PREFETCH;
      end
      PREFETCH: begin
        load_head = 1'b1;
        state_nxt = STREAM;
      end
      STREAM: begin
        pop_valid = ~wr_sys_rst;
        pop_acc   = pop;
        last_pop  = pop && (words_left == CNT_W'(1));
        if (last_pop) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wr_sys_clk) begin
    if (wr_en) mem[wr_ptr] <= s_data;
  end

  // rd_ptr always addresses the word shown on pop_data, so that word still
  // counts in level until it is popped. On a pop the following word is
  // fetched straight from the array, which keeps the stream bubble-free.
  always_ff @(posedge wr_sys_clk) begin
    if (wr_sys_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      words_left <= '0;
      pop_data   <= 16'h0000;
      frame_done <= 1'b0;
    end else begin
      frame_done <= last_pop;
      if (wr_en)   wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_acc) rd_ptr <= rd_ptr_inc;
      if (wr_en && !pop_acc)      level <= level + LEVEL_ONE;
      else if (!wr_en && pop_acc) level <= level - LEVEL_ONE;
      if (load_head) begin
        pop_data   <= mem[rd_ptr];
        words_left <= CNT_W'(FRAME_WORDS);
      end else if (pop_acc) begin
        pop_data   <= mem[rd_ptr_inc];
        words_left <= words_left - CNT_W'(1);
      end
    end
  end

`ifdef WRF_PAYLOAD_OVF_CNT_EN
  always_ff @(posedge wr_sys_clk) begin
    if (wr_sys_rst)
      ovf_cnt <= 16'h0000;
    else if (s_valid && !s_ready && ovf_cnt != 16'hFFFF)
      ovf_cnt <= ovf_cnt + 16'h0001;
  end
`else
  assign ovf_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_wrf_payload_fifo.sv
// tb_wrf_payload_fifo
//   Directed bench for wrf_payload_fifo: a table of fill levels checked from
//   reset, then hand-written frame, stall, overflow, reset-mid-frame and
//   steady-state streaming sequences checked against a queue model.
module tb_wrf_payload_fifo;

  localparam int DL2   = 9;
  localparam int DEPTH = 512;
  localparam int FW    = 106;

  logic          wr_sys_clk = 1'b0;
  logic          wr_sys_rst = 1'b1;
  logic [15:0]   s_data = 16'h0000;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          frame_ready;
  logic          frame_start = 1'b0;
  logic          pop_valid;
  logic [15:0]   pop_data;
  logic          pop = 1'b0;
  logic          frame_done;
  logic [DL2:0]  level;
  logic [15:0]   ovf_cnt;

  int checks = 0;
  int errors = 0;
  int ovf_m  = 0;
  logic [15:0] q[$];

  wrf_payload_fifo #(.DEPTH_LOG2(DL2), .FRAME_WORDS(FW)) dut (
    .wr_sys_clk  (wr_sys_clk),
    .wr_sys_rst  (wr_sys_rst),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .frame_ready (frame_ready),
    .frame_start (frame_start),
    .pop_valid   (pop_valid),
    .pop_data    (pop_data),
    .pop         (pop),
    .frame_done  (frame_done),
    .level       (level),
    .ovf_cnt     (ovf_cnt)
  );

  always #5 wr_sys_clk = ~wr_sys_clk;

  typedef struct {
    int   n_wr;
    logic exp_fr;
    logic exp_srdy;
    int   exp_level;
  } fill_vec_t;

  task automatic tick();
    @(posedge wr_sys_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int exp_ovf();
`ifdef WRF_PAYLOAD_OVF_CNT_EN
    return ovf_m;
`else
    return 0;
`endif
  endfunction

  task automatic do_reset();
    wr_sys_rst  = 1'b1;
    s_valid     = 1'b0;
    pop         = 1'b0;
    frame_start = 1'b0;
    tick();
    check("rst_s_ready", s_ready, 0);
    check("rst_level", level, 0);
    check("rst_pop_valid", pop_valid, 0);
    check("rst_frame_ready", frame_ready, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_pop_data", pop_data, 16'h0000);
    check("rst_ovf_cnt", ovf_cnt, 0);
    wr_sys_rst = 1'b0;
    #1;
    check("rel_s_ready", s_ready, 1);
    q.delete();
    ovf_m = 0;
  endtask

  task automatic write_words(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = 16'(base + i);
      check("wr_s_ready", s_ready, (q.size() < DEPTH) ? 1 : 0);
      if (q.size() < DEPTH) q.push_back(16'(base + i));
      else                  ovf_m++;
      tick();
    end
    s_valid = 1'b0;
  endtask

  // Runs one frame with continuous pop; optionally stalls before word
  // stall_at for stall_len cycles, or returns right after abort_at pops.
  task automatic run_frame(input int stall_at, input int stall_len, input int abort_at);
    check("pre_frame_ready", frame_ready, 1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("prefetch_pop_valid", pop_valid, 0);
    check("prefetch_frame_ready", frame_ready, 0);
    tick();
    for (int i = 0; i < FW; i++) begin
      if (i == abort_at) return;
      if (i == stall_at) begin
        for (int k = 0; k < stall_len; k++) begin
          tick();
          check("stall_pop_data", pop_data, q[0]);
          check("stall_pop_valid", pop_valid, 1);
        end
      end
      check("pop_valid", pop_valid, 1);
      check("pop_data", pop_data, q[0]);
      check("frame_done_early", frame_done, 0);
      pop = 1'b1;
      tick();
      pop = 1'b0;
      void'(q.pop_front());
    end
    check("frame_done_pulse", frame_done, 1);
    check("pop_valid_fall", pop_valid, 0);
    tick();
    check("frame_done_single", frame_done, 0);
    check("post_frame_level", level, q.size());
  endtask

  fill_vec_t fill_tab[7];

  initial begin
    fill_tab[0] = '{0,   1'b0, 1'b1, 0};
    fill_tab[1] = '{1,   1'b0, 1'b1, 1};
    fill_tab[2] = '{105, 1'b0, 1'b1, 105};
    fill_tab[3] = '{106, 1'b1, 1'b1, 106};
    fill_tab[4] = '{300, 1'b1, 1'b1, 300};
    fill_tab[5] = '{511, 1'b1, 1'b1, 511};
    fill_tab[6] = '{512, 1'b1, 1'b0, 512};

    for (int v = 0; v < 7; v++) begin
      do_reset();
      write_words(fill_tab[v].n_wr, 16'h0100);
      check("tab_frame_ready", frame_ready, fill_tab[v].exp_fr);
      check("tab_s_ready", s_ready, fill_tab[v].exp_srdy);
      check("tab_level", level, fill_tab[v].exp_level);
    end

    // One frame of 0x0001..0x006A, then a second frame with a mid-frame stall.
    do_reset();
    write_words(FW, 16'h0001);
    check("fr_after_106", frame_ready, 1);
    run_frame(-1, 0, -1);
    check("level_empty", level, 0);
    write_words(FW, 16'h0080);
    run_frame(40, 5, -1);

    // Frame start with one word short is ignored.
    do_reset();
    write_words(FW - 1, 16'h0300);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("short_fr", frame_ready, 0);
    check("short_pv0", pop_valid, 0);
    tick();
    check("short_pv1", pop_valid, 0);
    write_words(1, 16'h0300 + FW - 1);
    check("short_fr_raise", frame_ready, 1);
    run_frame(-1, 0, -1);

    // Fill past full, then frames across the pointer wrap.
    do_reset();
    write_words(DEPTH + 10, 16'h0200);
    check("ovf_level", level, DEPTH);
    check("ovf_cnt", ovf_cnt, exp_ovf());
    run_frame(-1, 0, -1);
    write_words(100, 16'h0500);
    for (int f = 0; f < 4; f++) run_frame(-1, 0, -1);
    check("wrap_level", level, q.size());

    // Reset at frame word 50.
    write_words(FW - q.size(), 16'h0600);
    run_frame(-1, 0, 50);
    wr_sys_rst = 1'b1;
    tick();
    check("mid_rst_level", level, 0);
    check("mid_rst_pop_valid", pop_valid, 0);
    check("mid_rst_ovf", ovf_cnt, 0);
    check("mid_rst_frame_done", frame_done, 0);
    wr_sys_rst = 1'b0;
    q.delete();
    ovf_m = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("mid_rst_no_done", frame_done, 0);
      check("mid_rst_pv", pop_valid, 0);
    end
    write_words(FW, 16'h0700);
    run_frame(-1, 0, -1);

    // Steady state: write on every accepted pop at level 200.
    do_reset();
    write_words(200, 16'h1000);
    pop = 1'b1;
    for (int c = 0; c < 300; c++) begin
      frame_start = frame_ready;
      if (pop_valid) begin
        check("ss_pop_data", pop_data, q[0]);
        void'(q.pop_front());
        s_valid = 1'b1;
        s_data  = 16'(16'h2000 + c);
        q.push_back(16'(16'h2000 + c));
      end else begin
        s_valid = 1'b0;
      end
      tick();
      check("ss_level", level, 200);
    end
    pop         = 1'b0;
    s_valid     = 1'b0;
    frame_start = 1'b0;
    tick();
    check("ss_final_level", level, q.size());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
